// File: rtl/lfsr_bus_read_master_if.sv
// Bus and output-stream signals of lfsr_bus_read_master.
// The master modport is the read sequencer, the slave modport is the peripheral array plus the downstream consumer.
interface lfsr_bus_read_master_if;
    logic [3:0]  a;
    logic        rd;
    logic [31:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [31:0] out_data;

    modport master (
        output a, rd, out_valid, out_addr, out_data,
        input  d_in, out_ready
    );

    modport slave (
        input  a, rd, out_valid, out_addr, out_data,
        output d_in, out_ready
    );
endinterface

// File: rtl/lfsr_bus_read_master.sv
// Read sequencer for the 16 LFSR peripherals, which buffers {addr, data} words in a first-word-fall-through FIFO.
// Optional macro XOR_CHK_EN adds the chk port, a running XOR of the words pushed during the current scan.
module lfsr_bus_read_master #(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0]                    first_addr,
    input  logic [4:0]                    count,
    output logic                          busy,
    output logic                          done,
`ifdef XOR_CHK_EN
    output logic [31:0]                   chk,
`endif
    lfsr_bus_read_master_if.master        bus
);

    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LAT_INIT = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
    localparam logic [PW:0]   DEPTH_V = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]   OCC_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, PUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cur_addr, a_q, hold_addr;
    logic [4:0]    remaining;
    logic [2:0]    lat_cnt;
    logic [31:0]   hold_data;

    logic [3:0]    mem_addr [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic          full, push, pop;

    assign full = (occ == DEPTH_V);
    assign push = (state_q == PUSH) && !full;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        bus.rd  = 1'b0;
        bus.a   = a_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = (count == 5'd0) ? DONE : ISSUE;
            ISSUE: begin
                bus.rd  = 1'b1;
                bus.a   = cur_addr;
                state_d = (RD_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT:    if (lat_cnt == 3'd0) state_d = CAPTURE;
            CAPTURE: state_d = PUSH;
            PUSH:    if (!full) state_d = (remaining > 5'd1) ? ISSUE : DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // a_q captures the issued address so 'a' holds through WAIT..PUSH and in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            a_q       <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cur_addr  <= first_addr;
                    remaining <= (count > 5'd16) ? 5'd16 : count;
                end
                ISSUE: begin
                    a_q     <= cur_addr;
                    lat_cnt <= LAT_INIT[2:0];
                end
                WAIT: if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
                CAPTURE: begin
                    hold_addr <= cur_addr;
                    hold_data <= bus.d_in;
                end
                PUSH: if (push) begin
                    cur_addr  <= cur_addr + 4'd1;
                    remaining <= remaining - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= hold_addr;
            mem_data[wr_ptr] <= hold_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: ;
            endcase
        end
    end

    // Head fields are forced to zero when empty so that a flush reads back as 0.
    assign bus.out_valid = (occ != '0);
    assign bus.out_addr  = bus.out_valid ? mem_addr[rd_ptr] : '0;
    assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : '0;

`ifdef XOR_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst)                          chk <= '0;
        else if (state_q == IDLE && start) chk <= '0;
        else if (push)                     chk <= chk ^ hold_data;
    end
`endif

endmodule

// File: doc/lfsr_bus_read_master.md
Name: lfsr_bus_read_master

Overview:
- Bus-side consumer for the 16 LFSR peripheral interfaces (addresses 0..15).
- Sequences read transactions: drives the 4-bit address and `rd` strobe, samples the shared 32-bit data bus a fixed latency later, and buffers {addr, data} words in a small FIFO.
- The FIFO is drained downstream with a valid/ready handshake.
- Sits between the peripheral array and any logger/processor of the random words.

Parameters:
- RD_LAT, 2, cycles from the `rd` assertion cycle to the cycle in which `d_in` is valid; legal range 1..7.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, 2..16.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a scan; ignored while busy=1
- first_addr  in  4  first peripheral address of the scan, sampled on start
- count  in  5  number of reads, sampled on start; 0..16 (values >16 clamp to 16)
- a  out  4  address to the peripheral interfaces
- rd  out  1  read strobe to the peripheral interfaces
- d_in  in  32  shared peripheral data bus
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_addr  out  4  address tag of the head word
- out_data  out  32  head data word
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at scan completion

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, regardless of the state in progress:
  - state IDLE, a=0, rd=0, busy=0, done=0
  - FIFO flushed, out_valid=0, out_addr=0, out_data=0
  - any in-flight read is abandoned with no push
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, PUSH, DONE.
- IDLE:
  - start=1 latches cur_addr=first_addr and remaining=min(count,16).
  - If remaining=0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - rd=1 for exactly this one cycle; a=cur_addr.
  - If RD_LAT=1, go to CAPTURE; otherwise go to WAIT with lat_cnt=RD_LAT-2.
- WAIT:
  - rd=0, a held.
  - Decrement lat_cnt; at 0, go to CAPTURE.
- CAPTURE:
  - Register d_in into hold_data and cur_addr into hold_addr.
  - This samples d_in exactly RD_LAT cycles after the ISSUE cycle.
  - Go to PUSH.
- PUSH:
  - If FIFO not full (occupancy evaluated at the start of the cycle): write {hold_addr, hold_data}, cur_addr=cur_addr+1 (mod 16, so 15 wraps to 0), remaining-=1.
  - Then go to ISSUE if remaining>0, else DONE.
  - If the FIFO is full: stall in PUSH with hold registers stable and no new rd.
  - A pop in the same cycle does not unblock the push until the next cycle.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- `a` holds its last value while in IDLE.
- FIFO:
  - First-word fall-through: out_valid=1 whenever occupancy>0; out_addr/out_data reflect the head.
  - Pop when out_valid and out_ready.
  - While out_valid=1 and out_ready=0, head fields are stable.
  - Push and pop in the same cycle (not full) leave occupancy unchanged.
  - Full = occupancy==FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Throughput: one read per RD_LAT+2 cycles when the FIFO never fills.
- start during busy, or in the same cycle as DONE, is ignored.
- Draining continues after done; a new scan may start while the FIFO still holds words.

Optional Feature:
- Macro XOR_CHK_EN.
- When defined:
  - Adds output port chk, 32 bits: a running XOR of every word pushed in the current scan.
  - chk clears to 0 on the cycle an accepted start is registered, and on reset.
  - chk is final and stable when done pulses and holds until the next accepted start.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: rst=0 for 2 cycles mid-scan (during WAIT) -> rd=0, a=0, busy=0, out_valid=0 next cycle; no word appears afterwards.
- Single read: RD_LAT=2, first_addr=5, count=1, d_in=32'hDEADBEEF driven at ISSUE+2, out_ready=1.
  - rd high for 1 cycle with a=5.
  - One word out with addr=5, data DEADBEEF.
  - done pulses 5 cycles after start.
- Wrap scan: first_addr=14, count=4 -> reads in order at addresses 14, 15, 0, 1; out_addr sequence 14, 15, 0, 1; exactly 4 rd pulses.
- Backpressure: FIFO_DEPTH=4, count=6, out_ready=0.
  - 4 words buffered; the FSM stalls in PUSH after the 5th capture with no 6th rd.
  - Raising out_ready drains all 6 in order with correct data; done after the 6th push.
- Edge inputs: count=0 -> done one cycle after IDLE→DONE with zero rd pulses. count=20 -> clamped to 16 reads. start while busy -> ignored.
- XOR_CHK_EN: data sequence 1, 2, 4 over count=3 -> chk=32'h00000007 at done; the next start clears chk to 0.
